program_counter_ctx: RTL
========================

# program_counter_ctx

Parametrised multi-context program counter for the processor front end. It holds the fetch PC and counts user-mode instruction advances against a time-slice quantum. On quantum expiry it saves the interrupted PC into a per-process context slot and vectors to the kernel. It also lets kernel code write, read and restore those slots. It generalises the single-context PC/quantum counter: address width, context count, quantum and vectors are parameters, and it adds context storage, automatic preemption and synchronous reset.

## Interface
- ADDR_WIDTH, 32, width of PC, jump target and context slots
- NUM_CTX, 4, number of process context slots; must be ≥2
- CTX_WIDTH, 2, width of context index; must satisfy 2^CTX_WIDTH ≥ NUM_CTX
- QUANTUM, 32, counted advances per time slice; must satisfy 1 ≤ QUANTUM ≤ 2^CNT_WIDTH
- CNT_WIDTH, 5, width of quantum counter
- RESET_VECTOR, 0, PC value after reset
- KERNEL_VECTOR, 16, PC loaded on quantum expiry
- Clock  in  1  single clock, rising-edge
- Reset  in  1  synchronous, active-high
- Halt  in  1  blocks sequential increment only
- Branch, Zero  in  1 each  taken branch when both are high
- Jump  in  1  unconditional jump
- JumpReg  in  1  register jump
- AddressJump  in  ADDR_WIDTH  target for branch/Jump/JumpReg
- ExecProc  in  1  high = kernel mode; advances are not counted
- ChangePc  in  1  restore: switch to context CtxSel
- CtxWrite  in  1  write PcIn into slot CtxSel
- CtxSel  in  CTX_WIDTH  slot index for write/restore/read
- PcIn  in  ADDR_WIDTH  data for CtxWrite
- PcOut  out  ADDR_WIDTH  current fetch address (registered PC)
- PcCounter  out  CNT_WIDTH  advances counted in current slice
- CurCtx  out  CTX_WIDTH  active context index
- SavedPc  out  ADDR_WIDTH  combinational read of slot CtxSel
- QuantumExpired  out  1  one-cycle pulse, registered

## Operation
- Reset values: PC=RESET_VECTOR, PcCounter=0, CurCtx=0, all slots=0, QuantumExpired=0. Reset overrides every other input.
- Candidate next PC, in priority order:
  - ChangePc: slot[CtxSel]. If CtxWrite is high in the same cycle, PcIn is used instead (write bypass).
  - Branch&&Zero: AddressJump.
  - Jump: AddressJump.
  - JumpReg: AddressJump.
  - !Halt: PC+1, modulo 2^ADDR_WIDTH.
  - Otherwise: hold.
- An "advance" is any non-hold, non-ChangePc update. Halt does not block branches or jumps.
- ChangePc effects: CurCtx<=CtxSel, PcCounter<=0, no expiry check.
- Counting: an advance with ExecProc low increments PcCounter. With ExecProc high, PcCounter holds.
- Expiry: an advance with ExecProc low while PcCounter==QUANTUM-1 triggers, in the same edge:
  - slot[CurCtx] <= candidate next PC
  - PC <= KERNEL_VECTOR
  - PcCounter <= 0
  - QuantumExpired <= 1
- QuantumExpired is 0 in every other cycle. CurCtx is unchanged by expiry.
- CtxWrite alone writes slot[CtxSel]<=PcIn and does not affect PC.
- CtxWrite and expiry on the same slot in the same cycle: the expiry save wins.
- CtxSel ≥ NUM_CTX: writes are ignored, SavedPc=0, and ChangePc loads RESET_VECTOR.
- PcCounter never exceeds QUANTUM-1. With QUANTUM=1, every counted advance expires.

## Timing
- All state updates on the rising edge of Clock. One-cycle latency from any control input to PcOut, PcCounter, CurCtx and QuantumExpired.
- SavedPc is combinational from CtxSel and the slot contents. It reflects a write on the cycle after the write edge.
- Control inputs are level-sampled each edge; there is no handshake. A held Jump re-jumps every cycle.
- Reset asserted mid-slice: the next edge yields the reset values. Slot contents are lost.

## Test plan
- Reset, then 3 cycles with Halt=0 and ExecProc=0 -> PcOut 0,1,2,3 and PcCounter 0,1,2,3.
- QUANTUM=4, ExecProc=0, free-run from PC=0 -> after the 4th advance PcOut=16, QuantumExpired pulses once, slot[0]=4, PcCounter=0.
- Halt=1 with Jump=1 and AddressJump=0x40 -> PcOut=0x40 and PcCounter increments. Halt=1 alone -> PC and counter hold.
- CtxWrite with CtxSel=2, PcIn=0x100; next cycle ChangePc with CtxSel=2 -> SavedPc=0x100, then PcOut=0x100, CurCtx=2, PcCounter=0. Same-cycle CtxWrite+ChangePc with PcIn=0x200 -> PcOut=0x200.
- ExecProc=1 for 10 advances -> PcCounter holds and no expiry occurs. Expiry cycle coinciding with Branch&&Zero to 0x80 -> slot saves 0x80 and PcOut=KERNEL_VECTOR.
- Reset asserted at PcCounter=3 with slot[1]=0x55 -> next cycle: all outputs at reset values, slot[1] reads 0.

Source files
------------

// File: rtl/program_counter_ctx_if.sv
// program_counter_ctx_if
// Bundles the front-end control, context-access and status signals of
// program_counter_ctx.
//   master : drives control/context inputs, observes PC and status
//   slave  : the program counter itself
interface program_counter_ctx_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CTX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 5
);
    logic                  halt;
    logic                  branch;
    logic                  zero;
    logic                  jump;
    logic                  jump_reg;
    logic [ADDR_WIDTH-1:0] address_jump;
    logic                  exec_proc;
    logic                  change_pc;
    logic                  ctx_write;
    logic [CTX_WIDTH-1:0]  ctx_sel;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [CNT_WIDTH-1:0]  pc_counter;
    logic [CTX_WIDTH-1:0]  cur_ctx;
    logic [ADDR_WIDTH-1:0] saved_pc;
    logic                  quantum_expired;

    modport master (
        output halt, branch, zero, jump, jump_reg, address_jump, exec_proc,
               change_pc, ctx_write, ctx_sel, pc_in,
        input  pc_out, pc_counter, cur_ctx, saved_pc, quantum_expired
    );

    modport slave (
        input  halt, branch, zero, jump, jump_reg, address_jump, exec_proc,
               change_pc, ctx_write, ctx_sel, pc_in,
        output pc_out, pc_counter, cur_ctx, saved_pc, quantum_expired
    );
endinterface

// File: rtl/program_counter_ctx.sv
// program_counter_ctx
// Multi-context fetch PC with a user-mode time-slice quantum. When the
// quantum runs out, the PC that would have been fetched next is saved in the
// active context slot and fetch vectors to KERNEL_VECTOR. Kernel code can
// write/read slots and restore (switch to) a context.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : program_counter_ctx_if.slave (control in, pc/status out)
module program_counter_ctx #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    NUM_CTX       = 4,
    parameter int                    CTX_WIDTH     = 2,
    parameter int                    QUANTUM       = 32,
    parameter int                    CNT_WIDTH     = 5,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter logic [ADDR_WIDTH-1:0] KERNEL_VECTOR = ADDR_WIDTH'(16)
) (
    input  logic                   clk,
    input  logic                   rst,
    program_counter_ctx_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] Q_LAST = CNT_WIDTH'(QUANTUM - 1);

    logic [NUM_CTX-1:0][ADDR_WIDTH-1:0] slots;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CTX_WIDTH-1:0]  cur_ctx;
    logic                  expired_q;

    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [ADDR_WIDTH-1:0] cand;
    logic                  advance;
    logic                  counted;
    logic                  expire;

    // Slot read by decode so an out-of-range ctx_sel reads 0 and is
    // recognisable for the ChangePc / write-ignore cases.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (bus.ctx_sel == CTX_WIDTH'(i)) begin
                sel_valid = 1'b1;
                sel_rd    = slots[i];
            end
        end
    end

    // Candidate next PC; ChangePc is a restore, not an advance.
    always_comb begin
        cand    = pc;
        advance = 1'b0;
        if (bus.change_pc) begin
            if (!sel_valid)         cand = RESET_VECTOR;
            else if (bus.ctx_write) cand = bus.pc_in;   // write bypass
            else                    cand = sel_rd;
        end else if ((bus.branch && bus.zero) || bus.jump || bus.jump_reg) begin
            cand    = bus.address_jump;
            advance = 1'b1;
        end else if (!bus.halt) begin
            cand    = pc + ADDR_WIDTH'(1);
            advance = 1'b1;
        end
    end

    assign counted = advance && !bus.exec_proc;
    assign expire  = counted && (cnt == Q_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_VECTOR;
            cnt       <= '0;
            cur_ctx   <= '0;
            expired_q <= 1'b0;
            slots     <= '0;
        end else begin
            expired_q <= expire;
            if (bus.change_pc) begin
                pc      <= cand;
                cur_ctx <= bus.ctx_sel;
                cnt     <= '0;
            end else if (expire) begin
                pc  <= KERNEL_VECTOR;
                cnt <= '0;
            end else begin
                pc <= cand;
                if (counted) cnt <= cnt + CNT_WIDTH'(1);
            end
            // Expiry save takes precedence over a kernel write to the same slot.
            for (int i = 0; i < NUM_CTX; i++) begin
                if (expire && cur_ctx == CTX_WIDTH'(i))
                    slots[i] <= cand;
                else if (bus.ctx_write && bus.ctx_sel == CTX_WIDTH'(i))
                    slots[i] <= bus.pc_in;
            end
        end
    end

    assign bus.pc_out          = pc;
    assign bus.pc_counter      = cnt;
    assign bus.cur_ctx         = cur_ctx;
    assign bus.saved_pc        = sel_rd;
    assign bus.quantum_expired = expired_q;
endmodule
